// File: rtl/neptune_tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neptune_tone_pkg
// Description : Shared constants for the tone pulse generator: note indices,
//               base half-period table at 1 MHz, detune shift and FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package neptune_tone_pkg;

    localparam logic [2:0] NOTE_E2   = 3'd0;
    localparam logic [2:0] NOTE_A2   = 3'd1;
    localparam logic [2:0] NOTE_D3   = 3'd2;
    localparam logic [2:0] NOTE_G3   = 3'd3;
    localparam logic [2:0] NOTE_B3   = 3'd4;
    localparam logic [2:0] NOTE_E4   = 3'd5;
    localparam logic [2:0] NUM_NOTES = 3'd6;

    // Detune step is base/128, i.e. roughly 0.78 % (about 13.5 cents) per LSB.
    localparam int DETUNE_SHIFT = 7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Half-period of each open string in clock cycles at 1 MHz.
    function automatic logic [12:0] base_half_1mhz(input logic [2:0] note);
        logic [12:0] v;
        case (note)
            NOTE_E2: v = 13'd6067;
            NOTE_A2: v = 13'd4545;
            NOTE_D3: v = 13'd3405;
            NOTE_G3: v = 13'd2551;
            NOTE_B3: v = 13'd2025;
            NOTE_E4: v = 13'd1517;
            default: v = 13'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_period_lut.sv
`default_nettype none
// ============================================================================
// Module      : tone_period_lut
// Description : Combinational note-to-half-period lookup with clock scaling
//               and signed detune.
//   note_sel : note index (0..5 valid)
//   detune   : signed pitch offset in units of base>>7
//   half     : effective half-period in clock cycles
//   valid    : note_sel names a real string
// Revision    : 1.0 - initial release
// ============================================================================
module tone_period_lut
    import neptune_tone_pkg::*;
#(
    parameter int CLK_HZ   = 1_000_000,
    parameter int DIV_W    = 20,
    parameter int DETUNE_W = 4
) (
    input  logic [2:0]                 note_sel,
    input  logic signed [DETUNE_W-1:0] detune,
    output logic [DIV_W-1:0]           half,
    output logic                       valid
);

    localparam logic [DIV_W-1:0] c_SCALE = DIV_W'(CLK_HZ / 1_000_000);

    logic [DIV_W-1:0]        w_base;
    logic signed [DIV_W+1:0] w_base_s;
    logic signed [DIV_W+1:0] w_step_s;
    logic signed [DIV_W+1:0] w_det_s;
    logic signed [DIV_W+1:0] w_sum;

    always_comb begin
        w_base   = DIV_W'(base_half_1mhz(note_sel)) * c_SCALE;
        // Two guard bits keep the signed sum from wrapping before truncation.
        w_base_s = signed'({2'b00, w_base});
        w_step_s = signed'({2'b00, (w_base >> DETUNE_SHIFT)});
        w_det_s  = (DIV_W+2)'(detune);
        w_sum    = w_base_s + w_det_s * w_step_s;
        half     = w_sum[DIV_W-1:0];
        valid    = (note_sel < NUM_NOTES);
    end

endmodule
`default_nettype wire

// File: rtl/tone_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tone_pulse_generator
// Description : 50 %-duty square-wave source at a selectable guitar-string
//               pitch with detune. Config loaded while running is held
//               pending and applied only on a rising edge of pulse_out.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : run request
//   load        : strobe sampling note_sel / detune
//   pulse_out   : square-wave output
//   period_done : strobe on each rising edge except the first
//   cfg_pending : a load awaits the next period boundary
//   load_err    : strobe for a load with an invalid note
//   active_note : note currently generated
// Revision    : 1.0 - initial release
// ============================================================================
module tone_pulse_generator
    import neptune_tone_pkg::*;
#(
    parameter int CLK_HZ   = 1_000_000,
    parameter int DIV_W    = 20,
    parameter int DETUNE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       load,
    input  logic [2:0]                 note_sel,
    input  logic signed [DETUNE_W-1:0] detune,
    output logic                       pulse_out,
    output logic                       period_done,
    output logic                       cfg_pending,
    output logic                       load_err,
    output logic [2:0]                 active_note
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] w_half;
    logic             w_valid;
    logic             w_load_ok;
    logic [DIV_W-1:0] w_start_half;

    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cur_half;
    logic [DIV_W-1:0] r_pend_half;
    logic [2:0]       r_pend_note;
    logic [2:0]       r_active_note;
    logic             r_cfg_valid;
    logic             r_cfg_pending;
    logic             r_pulse;
    logic             r_period_done;
    logic             r_load_err;

    tone_period_lut #(
        .CLK_HZ   (CLK_HZ),
        .DIV_W    (DIV_W),
        .DETUNE_W (DETUNE_W)
    ) u_lut (
        .note_sel (note_sel),
        .detune   (detune),
        .half     (w_half),
        .valid    (w_valid)
    );

    assign w_load_ok    = load && w_valid;
    // A load arriving on the start cycle already owns the first high phase.
    assign w_start_half = w_load_ok ? w_half : r_cur_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cur_half    <= '0;
            r_pend_half   <= '0;
            r_pend_note   <= '0;
            r_active_note <= '0;
            r_cfg_valid   <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_pulse       <= 1'b0;
            r_period_done <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            r_load_err    <= load && !w_valid;

            case (r_state)
                ST_IDLE: begin
                    r_pulse <= 1'b0;
                    if (w_load_ok) begin
                        r_cur_half    <= w_half;
                        r_active_note <= note_sel;
                        r_cfg_valid   <= 1'b1;
                    end
                    if (enable && r_cfg_valid) begin
                        r_state <= ST_RUN;
                        r_pulse <= 1'b1;
                        r_cnt   <= w_start_half - c_ONE;
                    end
                end

                ST_RUN: begin
                    if (!enable) begin
                        r_state       <= ST_IDLE;
                        r_pulse       <= 1'b0;
                        r_cfg_pending <= 1'b0;
                        if (r_cfg_pending) begin
                            r_cur_half    <= r_pend_half;
                            r_active_note <= r_pend_note;
                        end
                        // A simultaneous load wins over the promoted value.
                        if (w_load_ok) begin
                            r_cur_half    <= w_half;
                            r_active_note <= note_sel;
                        end
                    end else begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_ONE;
                        end else begin
                            r_pulse <= ~r_pulse;
                            if (!r_pulse) begin
                                r_period_done <= 1'b1;
                                if (r_cfg_pending) begin
                                    r_cur_half    <= r_pend_half;
                                    r_active_note <= r_pend_note;
                                    r_cfg_pending <= 1'b0;
                                    r_cnt         <= r_pend_half - c_ONE;
                                end else begin
                                    r_cnt <= r_cur_half - c_ONE;
                                end
                            end else begin
                                r_cnt <= r_cur_half - c_ONE;
                            end
                        end
                        // Placed last so a load on a boundary cycle stays pending.
                        if (w_load_ok) begin
                            r_pend_half   <= w_half;
                            r_pend_note   <= note_sel;
                            r_cfg_pending <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out   = r_pulse;
    assign period_done = r_period_done;
    assign cfg_pending = r_cfg_pending;
    assign load_err    = r_load_err;
    assign active_note = r_active_note;

endmodule
`default_nettype wire

// File: tb/tb_tone_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_pulse_generator
// Description : Self-checking bench for tone_pulse_generator: table of
//               note/detune vectors with hand-computed half-periods, plus
//               sequences for pending config, invalid loads and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_pulse_generator;

    localparam int c_LIMIT = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              load;
    logic [2:0]        note_sel;
    logic signed [3:0] detune;
    logic              pulse_out;
    logic              period_done;
    logic              cfg_pending;
    logic              load_err;
    logic [2:0]        active_note;

    int tests = 0;
    int fails = 0;

    tone_pulse_generator #(
        .CLK_HZ   (1_000_000),
        .DIV_W    (20),
        .DETUNE_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .note_sel    (note_sel),
        .detune      (detune),
        .pulse_out   (pulse_out),
        .period_done (period_done),
        .cfg_pending (cfg_pending),
        .load_err    (load_err),
        .active_note (active_note)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        note;
        logic signed [3:0] det;
        int                half;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts consecutive samples at level lvl, starting from 'start' samples
    // already seen; returns when the output leaves that level.
    task automatic measure(input logic lvl, input int start, output int cnt);
        cnt = start;
        tick();
        while (pulse_out == lvl && cnt < c_LIMIT) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_load(input logic [2:0] n, input logic signed [3:0] d);
        load     = 1'b1;
        note_sel = n;
        detune   = d;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        int n;
        int highs;

        // note, detune, half = base + det*(base>>7)
        vecs[0] = '{3'd1,  4'sd0, 4545};          // A2
        vecs[1] = '{3'd1,  4'sd4, 4545 + 4*35};   // 4685
        vecs[2] = '{3'd5, -4'sd8, 1517 - 8*11};   // 1429
        vecs[3] = '{3'd3, -4'sd3, 2551 - 3*19};   // 2494
        vecs[4] = '{3'd4,  4'sd2, 2025 + 2*15};   // 2055

        rst = 1'b1; enable = 1'b0; load = 1'b0; note_sel = '0; detune = '0;
        tick();
        tick();
        chk("rst_pulse",  int'(pulse_out), 0);
        chk("rst_pdone",  int'(period_done), 0);
        chk("rst_pend",   int'(cfg_pending), 0);
        chk("rst_lerr",   int'(load_err), 0);
        chk("rst_note",   int'(active_note), 0);
        rst = 1'b0;

        // Enable without any config must not start the tone.
        enable = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pulse_out) highs++;
        end
        chk("nocfg_idle", highs, 0);
        enable = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_load(vecs[i].note, vecs[i].det);
            chk($sformatf("v%0d_lerr", i), int'(load_err), 0);
            chk($sformatf("v%0d_note", i), int'(active_note), int'(vecs[i].note));
            enable = 1'b1;
            tick();
            chk($sformatf("v%0d_start", i), int'(pulse_out), 1);
            chk($sformatf("v%0d_pd_first", i), int'(period_done), 0);
            measure(1'b1, 1, n);
            chk($sformatf("v%0d_high", i), n, vecs[i].half);
            measure(1'b0, 1, n);
            chk($sformatf("v%0d_low", i), n, vecs[i].half);
            chk($sformatf("v%0d_pd", i), int'(period_done), 1);
            tick();
            chk($sformatf("v%0d_pd_clr", i), int'(period_done), 0);
            enable = 1'b0;
            tick();
            chk($sformatf("v%0d_stop", i), int'(pulse_out), 0);
        end

        // Mid-run load: held pending until the next rising edge.
        do_load(3'd0, 4'sd0);
        enable = 1'b1;
        tick();
        chk("mr_start", int'(pulse_out), 1);
        for (int i = 0; i < 10; i++) tick();
        do_load(3'd5, 4'sd0);
        chk("mr_pend", int'(cfg_pending), 1);
        chk("mr_note_old", int'(active_note), 0);
        measure(1'b1, 12, n);
        chk("mr_high_old", n, 6067);
        measure(1'b0, 1, n);
        chk("mr_low_old", n, 6067);
        chk("mr_pd", int'(period_done), 1);
        chk("mr_note_new", int'(active_note), 5);
        chk("mr_pend_clr", int'(cfg_pending), 0);
        measure(1'b1, 1, n);
        chk("mr_high_new", n, 1517);

        // Invalid note during RUN: error strobe only.
        do_load(3'd7, 4'sd0);
        chk("inv_lerr", int'(load_err), 1);
        chk("inv_note", int'(active_note), 5);
        chk("inv_pend", int'(cfg_pending), 0);
        tick();
        chk("inv_lerr_clr", int'(load_err), 0);
        measure(1'b0, 3, n);
        chk("inv_low", n, 1517);

        // Reset in the high phase clears config; restart needs a new load.
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_pulse", int'(pulse_out), 0);
        chk("mrst_note", int'(active_note), 0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse_out) highs++;
        end
        chk("mrst_stay_low", highs, 0);
        do_load(3'd1, 4'sd0);
        chk("re_load_cycle", int'(pulse_out), 0);
        tick();
        chk("re_start", int'(pulse_out), 1);
        measure(1'b1, 1, n);
        chk("re_high", n, 4545);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_pulse_generator.md
Name: tone_pulse_generator

Overview:
- Transmit-side counterpart of the tuner's pulse-measurement path.
- Generates a 50%-duty square wave at a selected guitar-string pitch, optionally detuned, to drive the tuner's `input_pulse` input.
- Used as an on-chip self-test source and as bench stimulus.
- Config changes in RUN take effect only at a period boundary, so the output never glitches.

Parameters:
- CLK_HZ, 1_000_000, system clock frequency; must be a multiple of 1 MHz.
- DIV_W, 20, width of the half-period counter and the effective half-period.
- DETUNE_W, 4, width of the signed detune input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  run request; low forces the output low and returns to IDLE.
- load  in  1  one-cycle strobe; samples note_sel and detune.
- note_sel  in  3  0=E2 1=A2 2=D3 3=G3 4=B3 5=E4; 6 and 7 are invalid.
- detune  in  DETUNE_W  signed two's-complement pitch offset, -8..+7.
- pulse_out  out  1  registered square-wave output.
- period_done  out  1  one-cycle strobe, coincident with each pulse_out 0->1 edge after the first.
- cfg_pending  out  1  a load is waiting for the next period boundary.
- load_err  out  1  one-cycle strobe when a load carries an invalid note_sel.
- active_note  out  3  note currently being generated.

Behaviour:
- Reset (synchronous, highest priority), on the next edge:
  - pulse_out=0, period_done=0, cfg_pending=0, load_err=0, active_note=0.
  - cfg_valid=0, state=IDLE.
- Base half-period table (cycles at 1 MHz): 6067, 4545, 3405, 2551, 2025, 1517.
- Base half-period: base = table[note] * (CLK_HZ/1_000_000).
- Effective half-period: half = base + detune * (base >> 7).
  - Compute at DIV_W+2 bits signed, then truncate to DIV_W.
- Load handling:
  - Invalid note_sel: load_err=1 on the next cycle; all config is unchanged.
  - Valid load in IDLE: cur_half, active_note and cfg_valid update on the next edge.
  - Valid load in RUN: stored in pend_half/pend_note and cfg_pending=1.
  - A second load while pending overwrites the pending value; no error.
- State IDLE:
  - pulse_out=0.
  - If enable && cfg_valid: go to RUN; pulse_out=1 and cnt=cur_half-1 on the next edge (latency 1 cycle).
- State RUN:
  - Each cycle with cnt!=0: cnt decrements.
  - When cnt==0: pulse_out toggles and cnt reloads to cur_half-1.
  - On a 0->1 toggle with cfg_pending: cur_half, active_note take the pending values, cfg_pending clears, and the reload uses the new half.
  - Changes never take effect on a 1->0 toggle, so the low phase of the current period is unaffected.
  - period_done is registered, asserted the same cycle pulse_out rises, except on the rising edge that enters RUN.
- enable low in RUN:
  - Next edge: state=IDLE, pulse_out=0.
  - Any pending config is promoted to cur (cfg_pending cleared).
- load and enable-fall in the same cycle: load is treated as an IDLE load and applied directly.
- Simultaneous load and boundary in RUN: the boundary uses the old pending value; the new load becomes pending.
- Resulting timing: pulse_out is high exactly half cycles and low exactly half cycles; period = 2*half.

Decomposition:
- Package neptune_tone_pkg:
  - note index localparams NOTE_E2..NOTE_E4, NUM_NOTES=6.
  - base half-period table at 1 MHz.
  - DETUNE_SHIFT=7.
  - state encoding IDLE/RUN.
- Sub-module tone_period_lut (combinational):
  - inputs note_sel, detune; outputs half[DIV_W-1:0] and valid.
  - Contains the table lookup, CLK_HZ scaling and detune arithmetic.
- The top level holds the FSM, counter and pending registers.

Test Plan:
- rst; load note=1 detune=0; enable=1 -> pulse_out rises 1 cycle later; high 4545 cycles, low 4545; period_done every 9090 cycles, active_note=1.
- load note=1 detune=+4 -> half=4545+4*35=4685; measured high/low 4685 each.
- load note=5 detune=-8 -> half=1517-8*11=1429; period 2858 cycles.
- Mid-run: running note=0; load note=5 during the high phase -> cfg_pending=1 immediately.
  - Current high and low phases stay 6067 each.
  - At the next rising edge: active_note=5, next high=1517, cfg_pending=0, period_done=1.
- load note_sel=7 during RUN -> load_err pulses one cycle; period and active_note unchanged; cfg_pending unchanged.
- Assert rst mid-high phase -> next edge pulse_out=0, IDLE.
  - With enable=1 but no new load, the output stays 0 (cfg_valid cleared).
  - After a load: restart with 1-cycle latency.
